// File: rtl/dmem_scan_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_scan_arbiter
//
// Purpose:
//   Shares the CPU's single data-memory port with a display refresh scanner.
//   The CPU always owns the port whenever it asks for it. The scanner uses the
//   idle cycles to copy display bytes from memory into local buffers.
//   - Char bank: DISP_BASE+0..3 (one byte per char digit)
//   - Num bank:  DISP_BASE+4..7 (one byte per numeric digit)
//   The buffered bytes drive a 4-digit char display and a 4-digit numeric
//   display, which are multiplexed one digit per refresh slot.
//
// Optional feature (compile-time macro): DISP_HEX_DECODE_EN
//   defined   : num = hex-to-7seg decode of the low nibble of the num byte
//   undefined : num = raw low 7 bits of the num byte (software supplies segments)
//
// Parameters:
//   DISP_BASE   first display address; must be 8-aligned
//   REFRESH_DIV clk cycles per digit slot (4..65535)
//   DIV_W       width of the refresh divider counter
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   cpu_req    CPU accesses data memory this cycle
//   cpu_we     CPU store strobe (only meaningful with cpu_req)
//   cpu_addr   CPU memory address
//   cpu_wdata  CPU store data
//   cpu_rdata  read data returned to the CPU (same cycle as mem_do)
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_di     memory write data
//   mem_do     memory read data (combinational read)
//   c_mask     char digit select, active-low one-hot
//   n_mask     num digit select, active-low one-hot
//   char       char segment pattern of the selected digit
//   num        num segment pattern of the selected digit, {g,f,e,d,c,b,a}
//   ovr_cnt    saturating count of refresh slots whose fetch was abandoned
// ---------------------------------------------------------------------------
module dmem_scan_arbiter #(
  parameter logic [7:0]  DISP_BASE   = 8'hF0,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned DIV_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_di,
  input  logic [7:0] mem_do,
  output logic [3:0] c_mask,
  output logic [3:0] n_mask,
  output logic [7:0] char,
  output logic [6:0] num,
  output logic [7:0] ovr_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_C = 2'd1,
    FETCH_N = 2'd2
  } scan_state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [4:0]       BANK_HI  = DISP_BASE[7:3];

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  scan_state_t      state;
  logic [7:0]       cbuf [4];
  logic [7:0]       nbuf [4];
  logic             tick;
  logic [7:0]       nsel;

  assign tick = (div == DIV_LAST);

  // Port mux. Because DISP_BASE is 8-aligned, the display addresses are just
  // the base's upper bits with the bank bit and digit index appended.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = cpu_addr;
    if (cpu_req) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
    end else if (state == FETCH_C) begin
      mem_addr = {BANK_HI, 1'b0, idx};
    end else if (state == FETCH_N) begin
      mem_addr = {BANK_HI, 1'b1, idx};
    end
  end

  assign mem_di    = cpu_wdata;
  assign cpu_rdata = mem_do;

  // Divider, digit index, fetch sequencer and overrun counter. A tick always
  // wins: any fetch still pending from the previous slot is dropped, so the
  // old digit's buffers simply keep their previous contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      idx     <= 2'd0;
      state   <= IDLE;
      ovr_cnt <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        cbuf[i] <= 8'h00;
        nbuf[i] <= 8'h00;
      end
    end else if (tick) begin
      div   <= '0;
      idx   <= idx + 2'd1;
      state <= FETCH_C;
      if (state != IDLE && ovr_cnt != 8'hFF) begin
        ovr_cnt <= ovr_cnt + 8'd1;
      end
    end else begin
      div <= div + DIV_W'(1);
      case (state)
        FETCH_C: begin
          if (!cpu_req) begin
            cbuf[idx] <= mem_do;
            state     <= FETCH_N;
          end
        end
        FETCH_N: begin
          if (!cpu_req) begin
            nbuf[idx] <= mem_do;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Digit selects follow idx, so they move the cycle after the tick.
  assign c_mask = ~(4'b0001 << idx);
  assign n_mask = ~(4'b0001 << idx);
  assign char   = cbuf[idx];
  assign nsel   = nbuf[idx];

`ifdef DISP_HEX_DECODE_EN
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Only the low nibble of a num byte is displayed in decode mode.
  logic [3:0] num_unused;
  assign num_unused = nsel[7:4];
  assign num        = hex7seg(nsel[3:0]);
`else
  // Raw mode: bit 7 of a num byte has no segment to drive.
  logic num_unused;
  assign num_unused = nsel[7];
  assign num        = nsel[6:0];
`endif

endmodule

// File: tb/tb_dmem_scan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_scan_arbiter
//
// Purpose:
//   Self-checking bench for dmem_scan_arbiter with REFRESH_DIV=4 and
//   DISP_BASE=8'hF0. A memory model sits on the mem_* port. A reference model
//   keeps a queue of pending display addresses per refresh slot and a copy of
//   the eight displayed bytes. Every cycle, all outputs are compared against
//   that reference model.
//   Honours DISP_HEX_DECODE_EN for the expected num values.
// ---------------------------------------------------------------------------
module tb_dmem_scan_arbiter;

  localparam int R = 4;

`ifdef DISP_HEX_DECODE_EN
  localparam logic [6:0] RESET_NUM = 7'h3F;
  localparam logic [6:0] NUM_0A    = 7'h77;
`else
  localparam logic [6:0] RESET_NUM = 7'h00;
  localparam logic [6:0] NUM_0A    = 7'h0A;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_wdata = 8'h00;
  logic [7:0] cpu_rdata;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_di;
  logic [7:0] mem_do;
  logic [3:0] c_mask;
  logic [3:0] n_mask;
  logic [7:0] char;
  logic [6:0] num;
  logic [7:0] ovr_cnt;

  always #5 clk = ~clk;

  dmem_scan_arbiter #(
    .DISP_BASE  (8'hF0),
    .REFRESH_DIV(R),
    .DIV_W      (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_do   (mem_do),
    .c_mask   (c_mask),
    .n_mask   (n_mask),
    .char     (char),
    .num      (num),
    .ovr_cnt  (ovr_cnt)
  );

  // Data memory: combinational read, synchronous write.
  logic [7:0] mem [256];
  assign mem_do = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_di;
  end

  // Reference model state.
  logic [7:0] ref_mem [256];
  logic [7:0] disp [8];
  logic [7:0] fq [$];
  int         cyc;
  int         ridx;
  int         rovr;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_cmp = 0;
  int n_bad = 0;

  // Values observed in the most recent applyStimulus cycle.
  logic [3:0] obs_cmask;
  logic [7:0] obs_char;
  logic [6:0] obs_num;
  logic [7:0] obs_ovr;
  logic [7:0] obs_addr;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] expNum(input logic [7:0] b);
`ifdef DISP_HEX_DECODE_EN
    return seg_tab[b[3:0]];
`else
    return b[6:0];
`endif
  endfunction

  task automatic modelReset();
    cyc  = 0;
    ridx = 0;
    rovr = 0;
    fq.delete();
    for (int i = 0; i < 8; i++) disp[i] = 8'h00;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic applyStimulus(input logic r, input logic req, input logic we,
                               input logic [7:0] a, input logic [7:0] d);
    logic [3:0] exp_mask;
    logic [7:0] exp_addr;
    logic [7:0] exp_char;
    logic [6:0] exp_num;
    logic [7:0] exp_ovr;
    logic       exp_we;
    logic [7:0] fa;
    @(negedge clk);
    rst       = r;
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    #1;
    exp_mask = 4'b1111;
    exp_mask[ridx] = 1'b0;
    exp_addr = (!req && fq.size() > 0) ? fq[0] : a;
    exp_char = disp[ridx];
    exp_num  = expNum(disp[4 + ridx]);
    exp_ovr  = 8'(rovr);
    exp_we   = req & we;
    checkOutput("c_mask",    c_mask,    exp_mask);
    checkOutput("n_mask",    n_mask,    exp_mask);
    checkOutput("char",      char,      exp_char);
    checkOutput("num",       num,       exp_num);
    checkOutput("ovr_cnt",   ovr_cnt,   exp_ovr);
    checkOutput("mem_addr",  mem_addr,  exp_addr);
    checkOutput("mem_we",    mem_we,    exp_we);
    checkOutput("mem_di",    mem_di,    d);
    checkOutput("cpu_rdata", cpu_rdata, mem[exp_addr]);
    obs_cmask = c_mask;
    obs_char  = char;
    obs_num   = num;
    obs_ovr   = ovr_cnt;
    obs_addr  = mem_addr;
    if (r) begin
      modelReset();
    end else begin
      if (cyc % R == R - 1) begin
        ridx = (ridx + 1) % 4;
        if (fq.size() > 0 && rovr < 255) rovr++;
        fq.delete();
        fq.push_back(8'(8'hF0 + ridx));
        fq.push_back(8'(8'hF4 + ridx));
      end else if (!req && fq.size() > 0) begin
        fa = fq.pop_front();
        disp[fa[2:0]] = ref_mem[fa];
      end
      if (req && we) ref_mem[a] = d;
      cyc++;
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
  endtask

  task automatic randomCycle();
    logic [7:0] a;
    a = ($urandom_range(0, 1) == 1) ? 8'(8'hF0 + $urandom_range(0, 7)) : 8'($urandom);
    applyStimulus(1'b0, ($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)), a, 8'($urandom));
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 8; i++) begin
      mem[8'hF0 + i]     = 8'(8'h11 + i);
      ref_mem[8'hF0 + i] = 8'(8'h11 + i);
    end

    // Reset held for two clocks, then reset values observed while still in reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    modelReset();
    @(negedge clk);
    #1;
    checkOutput("rst_c_mask", c_mask, 4'b1110);
    checkOutput("rst_n_mask", n_mask, 4'b1110);
    checkOutput("rst_char",   char,   8'h00);
    checkOutput("rst_num",    num,    RESET_NUM);
    checkOutput("rst_ovr",    ovr_cnt, 8'h00);

    // Scan order: first tick at cycle 3 fetches F1 then F5.
    repeat (5) idleCycle();
    checkOutput("scan_addr_c", obs_addr, 8'hF1);
    idleCycle();
    checkOutput("scan_addr_n", obs_addr, 8'hF5);
    repeat (13) idleCycle();
    checkOutput("scan_char0", obs_char,  8'h11);
    checkOutput("scan_mask0", obs_cmask, 4'b1110);

    // CPU priority right after a tick.
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (fq.size() == 2) found = 1'b1;
      else idleCycle();
    end
    checkOutput("prio_sync", found, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h20, 8'($urandom));
      checkOutput("prio_addr", obs_addr, 8'h20);
    end
    repeat (4) idleCycle();

    // Overrun: CPU hogs the port for 10 cycles.
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
    repeat (8) idleCycle();

    // Mixed random traffic.
    repeat (400) randomCycle();
    repeat (20) idleCycle();

    // Store then show on digit 0.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hF4, 8'h0A);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      idleCycle();
      if (ridx == 0 && fq.size() == 0 && disp[4] == 8'h0A) found = 1'b1;
    end
    checkOutput("store_show_seen", found, 1'b1);
    idleCycle();
    checkOutput("store_show_num", obs_num, NUM_0A);

    // Saturation of the overrun counter.
    repeat (2000) applyStimulus(1'b0, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
    checkOutput("ovr_sat", obs_ovr, 8'hFF);
    repeat (24) idleCycle();

    // Reset in the middle of a num-bank fetch.
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      idleCycle();
      if (fq.size() == 1) found = 1'b1;
    end
    checkOutput("midrst_sync", found, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h33, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h44, 8'h00);
    checkOutput("midrst_mask", obs_cmask, 4'b1110);
    checkOutput("midrst_char", obs_char,  8'h00);
    checkOutput("midrst_num",  obs_num,   RESET_NUM);
    checkOutput("midrst_ovr",  obs_ovr,   8'h00);
    checkOutput("midrst_addr", obs_addr,  8'h44);

    repeat (100) randomCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
